// File: rtl/fu_branch_pipe.sv
// Pipelined branch/jump functional unit: compare, target and link computed in stage 0, then carried LATENCY deep.
// Optional prediction check enabled by defining FU_BRANCH_PREDCHK_EN.
module fu_branch_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             jump,
  input  logic             jalr,
  input  logic [2:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
`ifdef FU_BRANCH_PREDCHK_EN
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             mispredict,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             taken,
  output logic             cmp_res,
  output logic [XLEN-1:0]  pc_jump,
  output logic [XLEN-1:0]  pc_wb,
  output logic             misalign
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
    $error("fu_branch_pipe: LATENCY must be in 1..4");
  end

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic             cmp_res;
    logic [XLEN-1:0]  pc_jump;
    logic [XLEN-1:0]  pc_wb;
    logic             misalign;
`ifdef FU_BRANCH_PREDCHK_EN
    logic             mispredict;
`endif
  } payload_t;

  logic [LATENCY-1:0] valid_q, valid_d;
  payload_t           data_q [LATENCY];
  payload_t           data_d [LATENCY];
  payload_t           s0;
  logic               adv;

  logic             lt_s, ltu_s, eq_s;
  logic [XLEN-1:0]  base_s, sum_s;

  always_comb begin
    eq_s   = (rs1_data == rs2_data);
    lt_s   = ($signed(rs1_data) < $signed(rs2_data));
    ltu_s  = (rs1_data < rs2_data);
    base_s = jalr ? rs1_data : pc;
    sum_s  = imm + base_s;
    // JALR clears bit 0 of the computed target
    if (jalr) sum_s[0] = 1'b0;

    s0         = '0;
    s0.tag     = in_tag;
    unique case (cmp_ctrl)
      3'b001:  s0.cmp_res = eq_s;
      3'b010:  s0.cmp_res = !eq_s;
      3'b011:  s0.cmp_res = lt_s;
      3'b100:  s0.cmp_res = ltu_s;
      3'b101:  s0.cmp_res = !lt_s;
      3'b110:  s0.cmp_res = !ltu_s;
      default: s0.cmp_res = 1'b0;
    endcase
    s0.taken    = jump | s0.cmp_res;
    s0.pc_jump  = sum_s;
    s0.pc_wb    = pc + XLEN'(4);
    s0.misalign = s0.taken & (|sum_s[1:0]);
`ifdef FU_BRANCH_PREDCHK_EN
    s0.mispredict = (s0.taken != pred_taken) |
                    (s0.taken & pred_taken & (sum_s != pred_target));
`endif
  end

  assign out_valid = valid_q[LATENCY-1];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;

  // Whole pipe moves together; flush overrides both advance and stall
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv) begin
      valid_d[0] = in_valid;
      data_d[0]  = s0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_tag  = data_q[LATENCY-1].tag;
  assign taken    = data_q[LATENCY-1].taken;
  assign cmp_res  = data_q[LATENCY-1].cmp_res;
  assign pc_jump  = data_q[LATENCY-1].pc_jump;
  assign pc_wb    = data_q[LATENCY-1].pc_wb;
  assign misalign = data_q[LATENCY-1].misalign;
`ifdef FU_BRANCH_PREDCHK_EN
  assign mispredict = data_q[LATENCY-1].mispredict;
`endif

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Directed self-checking bench for fu_branch_pipe (LATENCY=2, XLEN=32).
module tb_fu_branch_pipe;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 4;
  localparam int LATENCY = 2;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready;
  logic [TAG_W-1:0] in_tag;
  logic             jump, jalr;
  logic [2:0]       cmp_ctrl;
  logic [XLEN-1:0]  rs1_data, rs2_data, imm, pc;
  logic             out_valid, out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             taken, cmp_res, misalign;
  logic [XLEN-1:0]  pc_jump, pc_wb;
`ifdef FU_BRANCH_PREDCHK_EN
  logic             pred_taken = 1'b0;
  logic [XLEN-1:0]  pred_target = '0;
  logic             mispredict;
`endif

  int checkCount = 0;
  int failCount  = 0;
  logic [TAG_W-1:0] tagCnt = 4'h1;

  fu_branch_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .jump(jump), .jalr(jalr), .cmp_ctrl(cmp_ctrl),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
`ifdef FU_BRANCH_PREDCHK_EN
    .pred_taken(pred_taken), .pred_target(pred_target), .mispredict(mispredict),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .taken(taken), .cmp_res(cmp_res), .pc_jump(pc_jump), .pc_wb(pc_wb),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Presents one op for a single cycle; returns at the negedge after the accept edge
  task automatic applyStimulus(input logic [TAG_W-1:0] t, input logic j, input logic jr,
                               input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] im, input logic [31:0] p);
    @(negedge clk);
    in_valid = 1'b1; in_tag = t; jump = j; jalr = jr; cmp_ctrl = c;
    rs1_data = a; rs2_data = b; imm = im; pc = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic runOp(input string nm, input logic j, input logic jr, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] p, input logic eCmp, input logic eTaken,
                       input logic [31:0] ePj, input logic [31:0] eWb, input logic eMis);
    int cyc;
    logic [TAG_W-1:0] t;
    t = tagCnt;
    tagCnt++;
    applyStimulus(t, j, jr, c, a, b, im, p);
    cyc = 1;
    #1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput({nm, ".latency"}, 64'(cyc), 64'(LATENCY));
    checkOutput({nm, ".tag"}, 64'(out_tag), 64'(t));
    checkOutput({nm, ".cmp_res"}, 64'(cmp_res), 64'(eCmp));
    checkOutput({nm, ".taken"}, 64'(taken), 64'(eTaken));
    checkOutput({nm, ".pc_jump"}, 64'(pc_jump), 64'(ePj));
    checkOutput({nm, ".pc_wb"}, 64'(pc_wb), 64'(eWb));
    checkOutput({nm, ".misalign"}, 64'(misalign), 64'(eMis));
  endtask

  initial begin
    logic sawValid;
    logic [TAG_W-1:0] got[$];
    logic prevStall, sawLow;
    logic [TAG_W-1:0] sTag;
    logic [XLEN-1:0] sPj;
    int k;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_tag = '0; jump = 1'b0; jalr = 1'b0; cmp_ctrl = '0;
    rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset.pc_jump", 64'(pc_jump), 64'(0));
    checkOutput("reset.pc_wb", 64'(pc_wb), 64'(0));
    checkOutput("reset.taken", 64'(taken), 64'(0));
    checkOutput("reset.out_tag", 64'(out_tag), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset.in_ready", 64'(in_ready), 64'(1));

    runOp("blt",       0, 0, 3'b011, 32'hFFFF_FFFF, 32'h1, 32'h8, 32'h100, 1, 1, 32'h108, 32'h104, 0);
    runOp("bltu",      0, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h8, 32'h100, 0, 0, 32'h108, 32'h104, 0);
    runOp("beq_nt_odd",0, 0, 3'b001, 32'h1, 32'h2, 32'h2, 32'h100, 0, 0, 32'h102, 32'h104, 0);
    runOp("beq_t",     0, 0, 3'b001, 32'h7, 32'h7, 32'hC, 32'h200, 1, 1, 32'h20C, 32'h204, 0);
    runOp("bne_eq",    0, 0, 3'b010, 32'h5, 32'h5, 32'h8, 32'h300, 0, 0, 32'h308, 32'h304, 0);
    runOp("bge_signed",0, 0, 3'b101, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h400, 1, 1, 32'h3F8, 32'h404, 0);
    runOp("bgeu",      0, 0, 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h4, 32'h500, 0, 0, 32'h504, 32'h504, 0);
    runOp("cmp111",    0, 0, 3'b111, 32'h0, 32'h0, 32'h8, 32'h600, 0, 0, 32'h608, 32'h604, 0);
    runOp("jalr",      1, 1, 3'b000, 32'h203, 32'h0, 32'h0, 32'h300, 0, 1, 32'h202, 32'h304, 1);
    runOp("jalr_odd",  1, 1, 3'b000, 32'h1001, 32'h0, 32'h2, 32'h0, 0, 1, 32'h1002, 32'h4, 1);
    runOp("jal_wrap",  1, 0, 3'b000, 32'h0, 32'h0, 32'h4, 32'hFFFF_FFFC, 0, 1, 32'h0, 32'h0, 0);
    runOp("jal_cmpeq", 1, 0, 3'b001, 32'h3, 32'h3, 32'h10, 32'h700, 1, 1, 32'h710, 32'h704, 0);
    runOp("blt_mis",   0, 0, 3'b011, 32'h0, 32'h5, 32'h6, 32'h100, 1, 1, 32'h106, 32'h104, 1);

    // Back-to-back issue with back-pressure between cycles 3 and 7
    k = 0; prevStall = 1'b0; sawLow = 1'b0; sTag = '0; sPj = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      if (k < 4) begin
        in_valid = 1'b1; in_tag = TAG_W'(8 + k); jump = 1'b1; jalr = 1'b0;
        cmp_ctrl = 3'b000; pc = 32'h1000 + 32'(k * 16); imm = 32'h0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prevStall) begin
        checkOutput("stall.tag_hold", 64'(out_tag), 64'(sTag));
        checkOutput("stall.pcj_hold", 64'(pc_jump), 64'(sPj));
      end
      prevStall = out_valid && !out_ready;
      sTag = out_tag;
      sPj  = pc_jump;
      if (!in_ready) sawLow = 1'b1;
      if (out_valid && out_ready) got.push_back(out_tag);
      if (in_valid && in_ready) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("stall.in_ready_drop", 64'(sawLow), 64'(1));
    checkOutput("stall.count", 64'(got.size()), 64'(4));
    for (int i = 0; i < got.size() && i < 4; i++)
      checkOutput("stall.order", 64'(got[i]), 64'(8 + i));

    // Flush with two ops in flight and a third on the input
    @(negedge clk);
    in_valid = 1'b1; in_tag = 4'h1; jump = 1'b1; jalr = 1'b0; pc = 32'h800; imm = 32'h0;
    @(negedge clk);
    in_tag = 4'h2;
    @(negedge clk);
    in_tag = 4'h3; flush = 1'b1;
    #1;
    checkOutput("flush.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("flush.no_out", 64'(sawValid), 64'(0));
    runOp("post_flush", 0, 0, 3'b001, 32'h9, 32'h9, 32'h20, 32'h900, 1, 1, 32'h920, 32'h904, 0);

    // Flush while the result is stalled at the output
    out_ready = 1'b0;
    applyStimulus(4'hA, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'hA00);
    k = 0;
    #1;
    while (!out_valid && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput("stallflush.present", 64'(out_valid), 64'(1));
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("stallflush.dropped", 64'(out_valid), 64'(0));
    out_ready = 1'b1;

    // Asynchronous reset with an op in flight
    applyStimulus(4'hC, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h4, 32'hB00);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset.out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset.pc_jump", 64'(pc_jump), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("midreset.no_pulse", 64'(sawValid), 64'(0));
    checkOutput("midreset.in_ready", 64'(in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
